// File: rtl/port_rd_scheduler_pkg.sv
// ============================================================================
// Module  : hydra_pkg
// Brief   : Shared types and constants for the per-port read scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hydra_pkg;

  localparam int NUM_PRIOR = 8;
  localparam int PRIOR_W   = 3;
  localparam int CREDIT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  function automatic logic [CREDIT_W-1:0] wrr_weight(input logic [PRIOR_W-1:0] p);
    return {1'b0, p} + CREDIT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/port_rd_scheduler_if.sv
// ============================================================================
// Module  : port_rd_scheduler_if
// Brief   : Enqueue, grant/done handshake and status bundle of one port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface port_rd_scheduler_if;
  import hydra_pkg::*;

  logic               wrr_enable;
  logic               join_vld;
  logic [PRIOR_W-1:0] join_prior;
  logic               ready;
  logic               rd_done;
  logic               rd_req;
  logic [PRIOR_W-1:0] rd_prior;
  logic [NUM_PRIOR-1:0] queue_empty;
  logic               busy;
  logic               overflow;

  modport master (
    output wrr_enable, join_vld, join_prior, ready, rd_done,
    input  rd_req, rd_prior, queue_empty, busy, overflow
  );

  modport slave (
    input  wrr_enable, join_vld, join_prior, ready, rd_done,
    output rd_req, rd_prior, queue_empty, busy, overflow
  );

endinterface

`default_nettype wire

// File: rtl/port_rd_wrr_picker.sv
// ============================================================================
// Module  : port_rd_wrr_picker
// Brief   : Combinational queue pick for strict-priority or WRR policy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module port_rd_wrr_picker
  import hydra_pkg::*;
(
  input  logic [NUM_PRIOR-1:0]               i_queue_empty,
  input  logic [NUM_PRIOR-1:0][CREDIT_W-1:0] i_credits,
  input  logic                               i_wrr_enable,
  output logic                               o_pick_vld,
  output logic [PRIOR_W-1:0]                 o_pick_prior,
  output logic                               o_reload
);

  logic [NUM_PRIOR-1:0] w_nonempty;
  logic [NUM_PRIOR-1:0] w_eligible;
  logic [NUM_PRIOR-1:0] w_cand;

  always_comb begin
    w_nonempty = ~i_queue_empty;
    for (int p = 0; p < NUM_PRIOR; p++) begin
      w_eligible[p] = w_nonempty[p] && (i_credits[p] != '0);
    end
  end

  assign o_pick_vld = |w_nonempty;
  // An exhausted round reloads and picks from the fresh credits in the same cycle.
  assign o_reload   = i_wrr_enable && o_pick_vld && (w_eligible == '0);
  assign w_cand     = (i_wrr_enable && !o_reload) ? w_eligible : w_nonempty;

  always_comb begin
    o_pick_prior = '0;
    for (int p = 0; p < NUM_PRIOR; p++) begin
      if (w_cand[p]) o_pick_prior = PRIOR_W'(p);
    end
  end

endmodule

`default_nettype wire

// File: rtl/port_rd_scheduler.sv
// ============================================================================
// Module  : port_rd_scheduler
// Brief   : Per-port queue counters, WRR credits and grant/done FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module port_rd_scheduler
  import hydra_pkg::*;
#(
  parameter int COUNT_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  port_rd_scheduler_if.slave  bus
);

  localparam logic [COUNT_W-1:0] C_COUNT_MAX = '1;

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [NUM_PRIOR-1:0][COUNT_W-1:0]  r_count;
  logic [NUM_PRIOR-1:0][CREDIT_W-1:0] r_credit;
  logic                               r_overflow;
  logic [PRIOR_W-1:0]                 r_rd_prior;
  logic [NUM_PRIOR-1:0]               w_queue_empty;
  logic [NUM_PRIOR-1:0]               w_inc;
  logic [NUM_PRIOR-1:0]               w_dec;
  logic                               w_pick_vld;
  logic [PRIOR_W-1:0]                 w_pick_prior;
  logic                               w_reload;
  logic                               w_grant;

  always_comb begin
    for (int p = 0; p < NUM_PRIOR; p++) begin
      w_queue_empty[p] = (r_count[p] == '0);
      w_inc[p]         = bus.join_vld && (bus.join_prior == PRIOR_W'(p));
      w_dec[p]         = w_grant && (w_pick_prior == PRIOR_W'(p));
    end
  end

  port_rd_wrr_picker u_picker (
    .i_queue_empty (w_queue_empty),
    .i_credits     (r_credit),
    .i_wrr_enable  (bus.wrr_enable),
    .o_pick_vld    (w_pick_vld),
    .o_pick_prior  (w_pick_prior),
    .o_reload      (w_reload)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ready && w_pick_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT:   w_state_nxt = bus.rd_done ? IDLE : BUSY;
      BUSY:    if (bus.rd_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rd_prior <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) r_rd_prior <= w_pick_prior;
    end
  end

  // Enqueue and grant on the same queue cancel; a saturated counter holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PRIOR; p++) begin
        if (w_inc[p] && !w_dec[p]) begin
          if (r_count[p] == C_COUNT_MAX) r_overflow <= 1'b1;
          else                           r_count[p] <= r_count[p] + COUNT_W'(1);
        end else if (w_dec[p] && !w_inc[p]) begin
          r_count[p] <= r_count[p] - COUNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PRIOR; p++) begin
      if (!rst_n || !bus.wrr_enable) begin
        r_credit[p] <= wrr_weight(PRIOR_W'(p));
      end else if (w_grant && w_reload) begin
        r_credit[p] <= (w_pick_prior == PRIOR_W'(p)) ?
                       wrr_weight(PRIOR_W'(p)) - CREDIT_W'(1) : wrr_weight(PRIOR_W'(p));
      end else if (w_dec[p]) begin
        r_credit[p] <= r_credit[p] - CREDIT_W'(1);
      end
    end
  end

  assign bus.rd_req      = (r_state == GRANT);
  assign bus.busy        = (r_state != IDLE);
  assign bus.rd_prior    = r_rd_prior;
  assign bus.queue_empty = w_queue_empty;
  assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_port_rd_scheduler.sv
// ============================================================================
// Module  : tb_port_rd_scheduler
// Brief   : Self-checking bench with a queue-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_port_rd_scheduler;
  import hydra_pkg::*;

  localparam int MAXA = 4095;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  port_rd_scheduler_if ifa ();
  port_rd_scheduler_if ifb ();

  port_rd_scheduler #(.COUNT_W(12)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  port_rd_scheduler #(.COUNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: queue depths, WRR credits, handshake phase (0 idle, 1 grant, 2 busy)
  int m_cnt  [8];
  int m_cred [8];
  int m_phase;
  int m_prior;
  bit m_ovf;

  int dut_grants[$];
  int grant_cyc[$];

  function automatic logic [7:0] model_empty();
    logic [7:0] e;
    for (int p = 0; p < 8; p++) e[p] = (m_cnt[p] == 0);
    return e;
  endfunction

  function automatic logic [13:0] exp_vec();
    return {m_phase == 1, m_phase != 0, 3'(m_prior), model_empty(), m_ovf};
  endfunction

  function automatic logic [13:0] act_vec();
    return {ifa.rd_req, ifa.busy, ifa.rd_prior, ifa.queue_empty, ifa.overflow};
  endfunction

  task automatic model_clock(input bit rst, input bit wrr, input bit jv, input int jp,
                             input bit rdy, input bit done);
    bit grant;
    int gp;
    bit any_ne;
    int old_phase;
    if (rst) begin
      for (int p = 0; p < 8; p++) begin
        m_cnt[p]  = 0;
        m_cred[p] = p + 1;
      end
      m_phase = 0; m_prior = 0; m_ovf = 0;
      return;
    end
    grant = 0; gp = 0; any_ne = 0;
    for (int p = 0; p < 8; p++) if (m_cnt[p] > 0) any_ne = 1;
    if (m_phase == 0 && rdy && any_ne) begin
      for (int p = 7; p >= 0; p--)
        if (!grant && m_cnt[p] > 0 && (!wrr || m_cred[p] > 0)) begin grant = 1; gp = p; end
      if (!grant) begin
        for (int p = 0; p < 8; p++) m_cred[p] = p + 1;
        for (int p = 7; p >= 0; p--)
          if (!grant && m_cnt[p] > 0) begin grant = 1; gp = p; end
      end
    end
    if (!wrr) for (int p = 0; p < 8; p++) m_cred[p] = p + 1;
    else if (grant) m_cred[gp] = m_cred[gp] - 1;
    for (int p = 0; p < 8; p++) begin
      if (jv && jp == p && !(grant && gp == p)) begin
        if (m_cnt[p] == MAXA) m_ovf = 1;
        else m_cnt[p] = m_cnt[p] + 1;
      end else if (grant && gp == p && !(jv && jp == p)) begin
        m_cnt[p] = m_cnt[p] - 1;
      end
    end
    old_phase = m_phase;
    if (old_phase == 0)      m_phase = grant ? 1 : 0;
    else                     m_phase = done ? 0 : 2;
    if (grant) m_prior = gp;
  endtask

  task automatic step(input bit rst, input bit wrr, input bit jv, input int jp,
                      input bit rdy, input bit done);
    @(negedge clk);
    rst_n          = !rst;
    ifa.wrr_enable = wrr;
    ifa.join_vld   = jv;
    ifa.join_prior = 3'(jp);
    ifa.ready      = rdy;
    ifa.rd_done    = done;
    model_clock(rst, wrr, jv, jp, rdy, done);
    @(posedge clk);
    #1;
    cyc++;
    if (ifa.rd_req === 1'b1) begin
      dut_grants.push_back(int'(ifa.rd_prior));
      grant_cyc.push_back(cyc);
    end
  endtask

  task automatic run_drain(input bit wrr, input int cycles);
    int age = 99;
    for (int c = 0; c < cycles; c++) begin
      if (age < 99) age++;
      step(0, wrr, 0, 0, 1, age == 2);
      if (m_phase == 1) age = 0;
      n_checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL drain c=%0d: got %b want %b", c, act_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (act_vec() !== {1'b0, 1'b0, 3'd0, 8'hFF, 1'b0})
      $display("FAIL reset_values: got %b want %b", act_vec(), {1'b0, 1'b0, 3'd0, 8'hFF, 1'b0});
    else n_pass++;
  endtask

  task automatic test_strict();
    int exp_seq[3] = '{6, 3, 3};
    dut_grants.delete();
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 1, 6, 0, 0);
    n_checks++;
    if (act_vec() !== exp_vec()) $display("FAIL strict_enq: got %b want %b", act_vec(), exp_vec());
    else n_pass++;
    run_drain(0, 14);
    n_checks++;
    if (dut_grants.size() != 3) $display("FAIL strict_count: got %0d want 3", dut_grants.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < dut_grants.size(); i++) begin
      n_checks++;
      if (dut_grants[i] != exp_seq[i])
        $display("FAIL strict_seq[%0d]: got %0d want %0d", i, dut_grants[i], exp_seq[i]);
      else n_pass++;
    end
    n_checks++;
    if (ifa.queue_empty !== 8'hFF) $display("FAIL strict_empty: got %h want ff", ifa.queue_empty);
    else n_pass++;
  endtask

  task automatic test_wrr();
    int exp_seq[8] = '{2, 2, 2, 0, 2, 2, 2, 0};
    dut_grants.delete();
    grant_cyc.delete();
    for (int i = 0; i < 20; i++) step(0, 1, 1, (i % 2) ? 2 : 0, 0, 0);
    n_checks++;
    if (act_vec() !== exp_vec()) $display("FAIL wrr_enq: got %b want %b", act_vec(), exp_vec());
    else n_pass++;
    run_drain(1, 70);
    n_checks++;
    if (dut_grants.size() != 20) $display("FAIL wrr_count: got %0d want 20", dut_grants.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < dut_grants.size(); i++) begin
      n_checks++;
      if (dut_grants[i] != exp_seq[i])
        $display("FAIL wrr_seq[%0d]: got %0d want %0d", i, dut_grants[i], exp_seq[i]);
      else n_pass++;
    end
    for (int i = 1; i < 8 && i < grant_cyc.size(); i++) begin
      n_checks++;
      if (grant_cyc[i] - grant_cyc[i-1] != 3)
        $display("FAIL wrr_spacing[%0d]: got %0d want 3", i, grant_cyc[i] - grant_cyc[i-1]);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous_and_done_in_grant();
    step(0, 0, 1, 5, 0, 0);
    step(0, 0, 1, 5, 1, 0);
    n_checks++;
    if (ifa.rd_req !== 1'b1 || ifa.rd_prior !== 3'd5 || ifa.queue_empty[5] !== 1'b0)
      $display("FAIL simul: got req=%b prior=%0d empty5=%b want 1 5 0",
               ifa.rd_req, ifa.rd_prior, ifa.queue_empty[5]);
    else n_pass++;
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (ifa.busy !== 1'b0 || ifa.rd_req !== 1'b0)
      $display("FAIL done_in_grant: got busy=%b req=%b want 0 0", ifa.busy, ifa.rd_req);
    else n_pass++;
    n_checks++;
    if (act_vec() !== exp_vec()) $display("FAIL simul_model: got %b want %b", act_vec(), exp_vec());
    else n_pass++;
    run_drain(0, 6);
  endtask

  task automatic test_ready_low();
    int bad = 0;
    step(0, 0, 1, 4, 0, 0);
    step(0, 0, 1, 4, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (ifa.rd_req !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL ready_low: got %0d grant cycles want 0", bad);
    else n_pass++;
    run_drain(0, 10);
  endtask

  task automatic test_random();
    int errs = 0;
    bit wrr = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) wrr = !wrr;
      step(0, wrr, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        if (errs < 10) $display("FAIL random i=%0d: got %b want %b", i, act_vec(), exp_vec());
        errs++;
      end else n_pass++;
    end
    run_drain(0, 200);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 7, 0, 0);
    while (m_phase != 2 && guard < 10) begin
      step(0, 0, 0, 0, 1, 0);
      guard++;
    end
    n_checks++;
    if (ifa.busy !== 1'b1) $display("FAIL reset_mid_busy: got %b want 1", ifa.busy);
    else n_pass++;
    step(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (act_vec() !== {1'b0, 1'b0, 3'd0, 8'hFF, 1'b0})
      $display("FAIL reset_mid: got %b want %b", act_vec(), {1'b0, 1'b0, 3'd0, 8'hFF, 1'b0});
    else n_pass++;
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (act_vec() !== {1'b0, 1'b0, 3'd0, 8'hFF, 1'b0})
      $display("FAIL reset_done_ignored: got %b want %b", act_vec(), {1'b0, 1'b0, 3'd0, 8'hFF, 1'b0});
    else n_pass++;
  endtask

  task automatic test_saturation();
    int grants = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifb.join_vld = 1; ifb.join_prior = 3'd1; ifb.ready = 0; ifb.rd_done = 0;
      @(posedge clk); #1;
      if (i == 2) begin
        n_checks++;
        if (ifb.overflow !== 1'b0) $display("FAIL sat_early_ovf: got %b want 0", ifb.overflow);
        else n_pass++;
      end
    end
    n_checks++;
    if (ifb.overflow !== 1'b1 || ifb.queue_empty !== 8'hFD)
      $display("FAIL sat_full: got ovf=%b empty=%h want 1 fd", ifb.overflow, ifb.queue_empty);
    else n_pass++;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      ifb.join_vld = 0;
      ifb.ready    = 1;
      ifb.rd_done  = ifb.busy && !ifb.rd_req;
      @(posedge clk); #1;
      if (ifb.rd_req === 1'b1) grants++;
    end
    ifb.ready = 0; ifb.rd_done = 0;
    n_checks++;
    if (grants != 3) $display("FAIL sat_grants: got %0d want 3", grants);
    else n_pass++;
    n_checks++;
    if (ifb.queue_empty !== 8'hFF || ifb.overflow !== 1'b1)
      $display("FAIL sat_after: got empty=%h ovf=%b want ff 1", ifb.queue_empty, ifb.overflow);
    else n_pass++;
  endtask

  initial begin
    ifa.wrr_enable = 0; ifa.join_vld = 0; ifa.join_prior = 0; ifa.ready = 0; ifa.rd_done = 0;
    ifb.wrr_enable = 0; ifb.join_vld = 0; ifb.join_prior = 0; ifb.ready = 0; ifb.rd_done = 0;
    test_reset();
    test_strict();
    test_wrr();
    test_simultaneous_and_done_in_grant();
    test_ready_low();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
